// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES block scheduler.
package aes_sched_pkg;

  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_BYTES     = WORDS_PER_BLOCK * 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_FETCH = 3'd2,
    S_CRYPT = 3'd3,
    S_STORE = 3'd4,
    S_NEXT  = 3'd5,
    S_ERR   = 3'd6
  } sched_state_t;

  // ceil(size/16) using a 33-bit intermediate so 0xFFFF_FFFF cannot wrap
  function automatic logic [28:0] blocks_for_size(input logic [31:0] size_bytes);
    logic [32:0] padded;
    padded = {1'b0, size_bytes} + 33'd15;
    return padded[32:4];
  endfunction

endpackage

// File: rtl/aes_sched_watchdog.sv
// Per-state wait counter for the AES block scheduler; only present when
// AES_SCHED_TIMEOUT_EN is defined.
`ifdef AES_SCHED_TIMEOUT_EN
module aes_sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] cur;

  // cur counts the present cycle; clr marks the first cycle of a wait state
  always_comb begin
    count_d = '0;
    expired = 1'b0;
    if (clr) begin
      cur = CW'(1);
    end else begin
      cur = count_q + CW'(1);
    end
    if (en) begin
      expired = (cur >= CW'(TIMEOUT_CYCLES));
      if (expired) begin
        count_d = CW'(TIMEOUT_CYCLES);
      end else begin
        count_d = cur;
      end
    end else begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`endif

// File: rtl/aes_block_scheduler.sv
// Block-loop sequencer for multi-block AES jobs (key, fetch, crypt, store, next).
// Optional wait-state timeout and ERR state under `define AES_SCHED_TIMEOUT_EN.
module aes_block_scheduler
  import aes_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 28
`ifdef AES_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              change_key,
  input  logic [31:0]       size_data,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  output logic              key_start,
  input  logic              key_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              aes_start,
  input  logic              aes_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_done,
  output logic              last_block,
  output logic              busy,
  output logic              job_done,
  output logic [CNT_W-1:0]  blocks_done
`ifdef AES_SCHED_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  sched_state_t      state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  blocks_left_q, blocks_left_d;
  logic [CNT_W-1:0]  blocks_done_q, blocks_done_d;
  logic              key_start_q, key_start_d;
  logic              rd_req_q, rd_req_d;
  logic              aes_start_q, aes_start_d;
  logic              wr_req_q, wr_req_d;
  logic              job_done_q, job_done_d;
  logic              busy_q, busy_d;
  logic              last_block_q, last_block_d;

`ifdef AES_SCHED_TIMEOUT_EN
  logic err_q, err_d;
  logic in_wait;
  logic wd_expired;

  assign in_wait = (state_q == S_KEY) || (state_q == S_FETCH) ||
                   (state_q == S_CRYPT) || (state_q == S_STORE);

  aes_sched_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (key_start_q | rd_req_q | aes_start_q | wr_req_q),
    .en     (in_wait),
    .expired(wd_expired)
  );

  assign err = err_q;
`endif

  // Next-state, counter and address update
  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    blocks_left_d = blocks_left_q;
    blocks_done_d = blocks_done_q;
    job_done_d    = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rd_addr_d     = raddr;
            wr_addr_d     = waddr;
            blocks_left_d = CNT_W'(blocks_for_size(size_data));
            blocks_done_d = '0;
            if (blocks_left_d == '0) begin
              job_done_d = 1'b1;
            end else if (change_key) begin
              state_d = S_KEY;
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        // A done coinciding with its own request cycle is not accepted
        S_KEY: begin
          if (key_done && !key_start_q) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_KEY;
          end
        end
        S_FETCH: begin
          if (rd_done && !rd_req_q) begin
            state_d = S_CRYPT;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_CRYPT: begin
          if (aes_done && !aes_start_q) begin
            state_d = S_STORE;
          end else begin
            state_d = S_CRYPT;
          end
        end
        S_STORE: begin
          if (wr_done && !wr_req_q) begin
            state_d = S_NEXT;
          end else begin
            state_d = S_STORE;
          end
        end
        S_NEXT: begin
          blocks_done_d = blocks_done_q + CNT_W'(1);
          blocks_left_d = blocks_left_q - CNT_W'(1);
          rd_addr_d     = rd_addr_q + ADDR_W'(BLOCK_BYTES);
          wr_addr_d     = wr_addr_q + ADDR_W'(BLOCK_BYTES);
          if (blocks_left_q == CNT_W'(1)) begin
            job_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

`ifdef AES_SCHED_TIMEOUT_EN
      // An accepted done in the expiry cycle takes precedence over the timeout
      if (in_wait && (state_d == state_q) && wd_expired) begin
        state_d = S_ERR;
      end else begin
        state_d = state_d;
      end
`endif
    end

    key_start_d  = (state_d == S_KEY)   && (state_q != S_KEY);
    rd_req_d     = (state_d == S_FETCH) && (state_q != S_FETCH);
    aes_start_d  = (state_d == S_CRYPT) && (state_q != S_CRYPT);
    wr_req_d     = (state_d == S_STORE) && (state_q != S_STORE);
    busy_d       = (state_d != S_IDLE);
    last_block_d = busy_d && (blocks_left_d == CNT_W'(1));
`ifdef AES_SCHED_TIMEOUT_EN
    err_d        = (state_d == S_ERR);
`endif
  end

  // State, address, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      blocks_left_q <= '0;
      blocks_done_q <= '0;
      key_start_q   <= 1'b0;
      rd_req_q      <= 1'b0;
      aes_start_q   <= 1'b0;
      wr_req_q      <= 1'b0;
      job_done_q    <= 1'b0;
      busy_q        <= 1'b0;
      last_block_q  <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      blocks_left_q <= blocks_left_d;
      blocks_done_q <= blocks_done_d;
      key_start_q   <= key_start_d;
      rd_req_q      <= rd_req_d;
      aes_start_q   <= aes_start_d;
      wr_req_q      <= wr_req_d;
      job_done_q    <= job_done_d;
      busy_q        <= busy_d;
      last_block_q  <= last_block_d;
`ifdef AES_SCHED_TIMEOUT_EN
      err_q         <= err_d;
`endif
    end
  end

  assign key_start   = key_start_q;
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign aes_start   = aes_start_q;
  assign wr_req      = wr_req_q;
  assign wr_addr     = wr_addr_q;
  assign last_block  = last_block_q;
  assign busy        = busy_q;
  assign job_done    = job_done_q;
  assign blocks_done = blocks_done_q;

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Scoreboard bench for aes_block_scheduler; timeout scenario runs only with
// AES_SCHED_TIMEOUT_EN defined.
module tb_aes_block_scheduler;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 28;

  logic              clk = 1'b0;
  logic              rst, start, abort, change_key;
  logic [31:0]       size_data;
  logic [ADDR_W-1:0] raddr, waddr;
  logic              key_start, key_done, rd_req, rd_done, aes_start, aes_done;
  logic              wr_req, wr_done, last_block, busy, job_done;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [CNT_W-1:0]  blocks_done;
`ifdef AES_SCHED_TIMEOUT_EN
  logic              err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wr_q[$];
  int          exp_key_q[$];
  int          exp_done_q[$];

  always #5 clk = ~clk;

  aes_block_scheduler #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
`ifdef AES_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .change_key (change_key),
    .size_data  (size_data),
    .raddr      (raddr),
    .waddr      (waddr),
    .key_start  (key_start),
    .key_done   (key_done),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .aes_start  (aes_start),
    .aes_done   (aes_done),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_done    (wr_done),
    .last_block (last_block),
    .busy       (busy),
    .job_done   (job_done),
    .blocks_done(blocks_done)
`ifdef AES_SCHED_TIMEOUT_EN
    ,
    .err        (err)
`endif
  );

  // Scoreboard: every request / completion must match the next queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (key_start === 1'b1) begin
        n_checks++;
        if (exp_key_q.size() == 0) begin
          n_fail++;
          $display("FAIL key_start: got unexpected pulse, required none");
        end else begin
          void'(exp_key_q.pop_front());
        end
      end
      if (rd_req === 1'b1) begin
        n_checks++;
        if (exp_rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_req: got unexpected pulse at %h, required none", rd_addr);
        end else begin
          logic [31:0] e;
          e = exp_rd_q.pop_front();
          if (rd_addr !== e) begin
            n_fail++;
            $display("FAIL rd_addr: got %h required %h", rd_addr, e);
          end
        end
      end
      if (wr_req === 1'b1) begin
        n_checks++;
        if (exp_wr_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_req: got unexpected pulse at %h, required none", wr_addr);
        end else begin
          logic [31:0] e;
          e = exp_wr_q.pop_front();
          if (wr_addr !== e) begin
            n_fail++;
            $display("FAIL wr_addr: got %h required %h", wr_addr, e);
          end
        end
      end
      if (job_done === 1'b1) begin
        n_checks++;
        if (exp_done_q.size() == 0) begin
          n_fail++;
          $display("FAIL job_done: got unexpected pulse, required none");
        end else begin
          int e;
          e = exp_done_q.pop_front();
          if (blocks_done !== CNT_W'(e)) begin
            n_fail++;
            $display("FAIL blocks_done: got %0d required %0d", blocks_done, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic req_of(input int k);
    case (k)
      0: return key_start;
      1: return rd_req;
      2: return aes_start;
      default: return wr_req;
    endcase
  endfunction

  task automatic pulse_done(input int k);
    case (k)
      0: key_done = 1'b1;
      1: rd_done  = 1'b1;
      2: aes_done = 1'b1;
      default: wr_done = 1'b1;
    endcase
    tick();
    key_done = 1'b0;
    rd_done  = 1'b0;
    aes_done = 1'b0;
    wr_done  = 1'b0;
  endtask

  // Wait (bounded) for a request, then answer it on the following cycle
  task automatic serve(input int k, input string name);
    int waited;
    waited = 0;
    while (req_of(k) !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    if (req_of(k) !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_wait: got no request within 40 cycles, required one", name);
    end else begin
      tick();
      pulse_done(k);
    end
  endtask

  task automatic wait_job_done(input string name);
    int waited;
    waited = 0;
    while (job_done !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (job_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_job_done: got no pulse within 20 cycles, required one", name);
    end else if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_at_done: got %b required 0", name, busy);
    end
    tick();
  endtask

  task automatic run_job(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] sz,
                         input bit key, input bit glitch, input string name);
    int nb;
    nb = int'((sz + 32'd15) >> 4);
    if (key) exp_key_q.push_back(1);
    for (int b = 0; b < nb; b++) begin
      exp_rd_q.push_back(ra + 32'(16 * b));
      exp_wr_q.push_back(wa + 32'(16 * b));
    end
    exp_done_q.push_back(nb);
    raddr = ra; waddr = wa; size_data = sz; change_key = key;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (key) serve(0, {name, "_key"});
    for (int b = 0; b < nb; b++) begin
      if (glitch && b == 0) begin
        for (int w = 0; w < 40 && rd_req !== 1'b1; w++) tick();
        // same-cycle rd_done, spurious aes_done and a second start: all ignored
        rd_done = 1'b1; aes_done = 1'b1; start = 1'b1; raddr = 32'h0000_5000; size_data = 32'd0;
        tick();
        rd_done = 1'b0; aes_done = 1'b0; start = 1'b0;
        for (int c = 0; c < 3; c++) begin
          n_checks++;
          if (aes_start !== 1'b0 || busy !== 1'b1 || rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_glitch: got aes_start=%b busy=%b rd_req=%b required 0 1 0",
                     name, aes_start, busy, rd_req);
          end
          tick();
        end
        pulse_done(1);
      end else begin
        serve(1, {name, "_rd"});
      end
      n_checks++;
      if (last_block !== (b == nb - 1)) begin
        n_fail++;
        $display("FAIL %s_last_block blk%0d: got %b required %b", name, b, last_block, (b == nb - 1));
      end
      serve(2, {name, "_aes"});
      serve(3, {name, "_wr"});
    end
    wait_job_done(name);
    n_checks++;
    if (exp_rd_q.size() != 0 || exp_wr_q.size() != 0 || exp_key_q.size() != 0 || exp_done_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got rd=%0d wr=%0d key=%0d done=%0d pending, required 0",
               name, exp_rd_q.size(), exp_wr_q.size(), exp_key_q.size(), exp_done_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; change_key = 1'b0; size_data = 32'd0;
    raddr = 32'd0; waddr = 32'd0;
    key_done = 1'b0; rd_done = 1'b0; aes_done = 1'b0; wr_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if ({key_start, rd_req, aes_start, wr_req, last_block, busy, job_done} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000",
               {key_start, rd_req, aes_start, wr_req, last_block, busy, job_done});
    end
    n_checks++;
    if (rd_addr !== 32'd0 || wr_addr !== 32'd0 || blocks_done !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got rd=%h wr=%h cnt=%0d required 0 0 0", rd_addr, wr_addr, blocks_done);
    end
  endtask

  task automatic test_two_blocks_key();
    run_job(32'h0000_0100, 32'h0000_0200, 32'd32, 1'b1, 1'b0, "two_key");
  endtask

  task automatic test_zero_size();
    exp_done_q.push_back(0);
    raddr = 32'h0000_1000; waddr = 32'h0000_2000; size_data = 32'd0; change_key = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (job_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got job_done=%b busy=%b required 1 0", job_done, busy);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || job_done !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_idle: got busy=%b job_done=%b required 0 0", busy, job_done);
      end
    end
  endtask

  task automatic test_size17();
    run_job(32'h0000_3000, 32'h0000_4000, 32'd17, 1'b0, 1'b0, "size17");
  endtask

  task automatic test_abort();
    exp_rd_q.push_back(32'h0000_0400);
    raddr = 32'h0000_0400; waddr = 32'h0000_0800; size_data = 32'd48; change_key = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(1, "abort_rd");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || blocks_done !== 28'd0 || last_block !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b cnt=%0d last=%b required 0 0 0", busy, blocks_done, last_block);
    end
    // stray done pulses after abort must not revive the job
    aes_done = 1'b1; wr_done = 1'b1;
    tick();
    aes_done = 1'b0; wr_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (busy !== 1'b0 || job_done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet: got busy=%b job_done=%b required 0 0", busy, job_done);
      end
      tick();
    end
    start = 1'b1; abort = 1'b1; size_data = 32'd16;
    tick();
    start = 1'b0; abort = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || job_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wins: got busy=%b job_done=%b required 0 0", busy, job_done);
    end
    run_job(32'h0000_0400, 32'h0000_0800, 32'd48, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back_wrap();
    run_job(32'hFFFF_FFF0, 32'h0000_0300, 32'd32, 1'b0, 1'b1, "wrap");
  endtask

`ifdef AES_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    exp_rd_q.push_back(32'h0000_0600);
    raddr = 32'h0000_0600; waddr = 32'h0000_0700; size_data = 32'd16; change_key = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 40 && rd_req !== 1'b1; w++) tick();
    for (int c = 1; c < 8; c++) tick();
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got err=%b in FETCH cycle 8, required 0", err);
    end
    tick();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%b busy=%b required 1 1", err, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort: got err=%b busy=%b required 0 0", err, busy);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_two_blocks_key();
    test_zero_size();
    test_size17();
    test_abort();
    test_back_to_back_wrap();
`ifdef AES_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
